// File: rtl/sync_updown_counter4bit_pkg.sv
// Shared definitions for the 4-bit synchronous up/down counter.
//   CNT_WIDTH : width of the count register and parallel-load bus.
//   cnt_t     : convenience type for internal count values.
package sync_updown_counter4bit_pkg;

  localparam int CNT_WIDTH = 4;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage : sync_updown_counter4bit_pkg

// File: rtl/sync_updown_counter4bit_jk_ff.sv
// Single JK flip-flop, one instance per count bit.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, forces q to 0
//   j   : set request
//   k   : reset request
//   q   : registered state
// Truth table: jk = 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule : jk_ff

// File: rtl/sync_updown_counter4bit.sv
// 4-bit synchronous up/down counter built from per-bit JK flip-flops, with
// parallel load (clamped to MOD-1), count enable, programmable modulus and a
// combinational terminal-count flag.
// Parameters:
//   counting modulus (MOD parameter), legal range 2..16; count covers 0..MOD-1
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (highest priority)
//   en   : count enable; q holds when low
//   up   : direction, 1 = up, 0 = down
//   load : synchronous parallel load strobe (beats en)
//   d    : parallel load value
//   q    : current count, registered
//   tc   : high in the cycle before a wrap
module sync_updown_counter4bit
  import sync_updown_counter4bit_pkg::*;
#(
  parameter int MOD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] d,
  output logic [CNT_WIDTH-1:0] q,
  output logic                 tc
);

  localparam cnt_t MAX_VAL = CNT_WIDTH'(MOD - 1);

  cnt_t cnt_q;     // state held in the JK flops
  cnt_t cnt_d;     // desired next state
  cnt_t j_vec;
  cnt_t k_vec;
  cnt_t load_val;
  logic at_max;
  logic at_zero;

  assign at_max   = (cnt_q == MAX_VAL);
  assign at_zero  = (cnt_q == '0);
  assign load_val = (d > MAX_VAL) ? MAX_VAL : d;

  // Priority: rst > load > en > hold. An out-of-range state is not
  // corrected: up still increments (4-bit overflow wraps 15 -> 0) and down
  // still decrements, because at_max/at_zero never match there.
  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up) cnt_d = at_max  ? '0      : cnt_q + cnt_t'(1);
      else    cnt_d = at_zero ? MAX_VAL : cnt_q - cnt_t'(1);
    end
  end

  // Translate the desired next state into JK drive: bits that must rise
  // are set, bits that must fall are reset, unchanged bits hold.
  assign j_vec = ~cnt_q &  cnt_d;
  assign k_vec =  cnt_q & ~cnt_d;

  for (genvar i = 0; i < CNT_WIDTH; i++) begin : g_bit
    jk_ff u_jk_ff (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[i]),
      .k   (k_vec[i]),
      .q   (cnt_q[i])
    );
  end

  assign q  = cnt_q;
  assign tc = en & ~load & ~rst & ((up & at_max) | (~up & at_zero));

endmodule : sync_updown_counter4bit

// File: tb/tb_sync_updown_counter4bit.sv
// Scoreboard bench for sync_updown_counter4bit. Two instances, one with
// modulus 16 and one with modulus 10, share one stimulus stream; each has
// its own reference model and expectation queue.
module tb_sync_updown_counter4bit;

  typedef struct {
    logic [3:0] q;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] d;
  logic [3:0] q_a, q_b;
  logic       tc_a, tc_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mq_a  = 0;
  int   mq_b  = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];

  always #5 clk = ~clk;

  sync_updown_counter4bit #(.MOD(16)) dut_a (
    .clk (clk), .rst (rst), .en (en), .up (up), .load (load),
    .d (d), .q (q_a), .tc (tc_a)
  );

  sync_updown_counter4bit #(.MOD(10)) dut_b (
    .clk (clk), .rst (rst), .en (en), .up (up), .load (load),
    .d (d), .q (q_b), .tc (tc_b)
  );

  // Reference model: plain integer arithmetic modulo the counter's modulus.
  function automatic int model_next(input int cur, input int mod,
                                    input logic r, input logic l,
                                    input logic e, input logic u,
                                    input int dv);
    if (r)      return 0;
    if (l)      return (dv > mod - 1) ? mod - 1 : dv;
    if (!e)     return cur;
    if (u)      return (cur + 1) % mod;
    return (cur + mod - 1) % mod;
  endfunction

  function automatic logic model_tc(input int cur, input int mod,
                                    input logic r, input logic l,
                                    input logic e, input logic u);
    if (r || l || !e) return 1'b0;
    return u ? (cur == mod - 1) : (cur == 0);
  endfunction

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Driver: apply inputs at negedge and push what the DUT must show during
  // this cycle (current q, tc for these inputs), then advance the models.
  task automatic step(input logic r, input logic l, input logic e,
                      input logic u, input logic [3:0] dv);
    exp_t ea, eb;
    @(negedge clk);
    rst = r; load = l; en = e; up = u; d = dv;
    ea.q  = 4'(mq_a);
    ea.tc = model_tc(mq_a, 16, r, l, e, u);
    eb.q  = 4'(mq_b);
    eb.tc = model_tc(mq_b, 10, r, l, e, u);
    sb_a.push_back(ea);
    sb_b.push_back(eb);
    mq_a = model_next(mq_a, 16, r, l, e, u, int'(dv));
    mq_b = model_next(mq_b, 10, r, l, e, u, int'(dv));
  endtask

  // Monitor: sample well after inputs settle and before the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        check("q_mod16",  int'(q_a),  int'(e.q));
        check("tc_mod16", int'(tc_a), int'(e.tc));
      end
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        check("q_mod10",  int'(q_b),  int'(e.q));
        check("tc_mod10", int'(tc_b), int'(e.tc));
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; d = 4'd0;
    repeat (2) @(negedge clk);
    mq_a = 0;
    mq_b = 0;

    // Reset state with everything idle.
    step(0, 0, 0, 1, 0);

    // Up count through the wrap.
    repeat (20) step(0, 0, 1, 1, 0);

    // Down count from reset through the wrap.
    step(1, 0, 1, 1, 0);
    repeat (17) step(0, 0, 1, 0, 0);

    // Load 3, count down through 0, then a clamped load of 12.
    step(1, 0, 0, 1, 0);
    repeat (11) step(0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 4'd3);
    repeat (5) step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 4'd12);

    // Hold with en low.
    repeat (5) step(0, 0, 0, 1, 0);

    // Load beats enable; rst beats load.
    step(1, 0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 4'd7);
    step(0, 1, 1, 1, 4'd15);
    step(1, 1, 1, 1, 4'd9);

    // Reset pulse mid-count, then resume.
    repeat (6) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 1, 0);

    // Direction flip at the top of the range.
    step(1, 0, 0, 1, 0);
    repeat (15) step(0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

    // Idle cycle so the last edge's result is observed.
    step(0, 0, 0, 1, 0);

    for (int i = 0; i < 10 && (sb_a.size() > 0 || sb_b.size() > 0); i++)
      @(negedge clk);
    #5;
    if (sb_a.size() > 0 || sb_b.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0",
               sb_a.size(), sb_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sync_updown_counter4bit
